uart_tx_scheduler: RTL

- Sequencer and arbiter in front of the UART transmitter.
- Serves two requesters on a round-robin basis:
  - Port A: single byte, e.g. a register-file read.
  - Port B: 2*DATA_WIDTH word, e.g. an ALU result, sent LSB byte first.
- Drives the transmitter's parallel data, data-valid pulse and parity configuration.
- Paces each byte on the transmitter's busy flag.

---
 rtl/uart_tx_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin sequencer in front of a UART transmitter: one byte from port A or a two-byte word from port B.
// Optional busy-rise timeout with sticky error and byte resend is enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_req_i,
    input  logic [DATA_WIDTH-1:0]   a_data_i,
    output logic                    a_ack_o,
    input  logic                    b_req_i,
    input  logic [2*DATA_WIDTH-1:0] b_data_i,
    output logic                    b_ack_o,
    input  logic                    cfg_par_en_i,
    input  logic                    cfg_par_type_i,
    input  logic                    tx_busy_i,
    output logic [DATA_WIDTH-1:0]   tx_p_data_o,
    output logic                    tx_data_valid_o,
    output logic                    tx_par_en_o,
    output logic                    tx_par_type_o,
    output logic                    sched_busy_o,
    output logic                    tx_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_HI, S_WAIT_LO} state_e;

    state_e                  state_q, state_d;
    logic                    prefer_b_q, prefer_b_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic                    a_ack_q, a_ack_d;
    logic                    b_ack_q, b_ack_d;
    logic                    valid_q, valid_d;
    logic                    par_en_q, par_en_d;
    logic                    par_type_q, par_type_d;
    logic                    busy_q, busy_d;
    logic                    grant_a, grant_b;
    logic                    timeout;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    // On contention the pointer hands the grant to the port that did not win last time.
    assign grant_b = (state_q == S_IDLE) && b_req_i && (!a_req_i || prefer_b_q);
    assign grant_a = (state_q == S_IDLE) && a_req_i && !grant_b;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] to_cnt_q;
    logic          err_q;

    assign timeout = (to_cnt_q == CW'(TIMEOUT_CYC - 1)) && !tx_busy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_WAIT_HI) ? to_cnt_q + 1'b1 : '0;
            if (state_q == S_WAIT_HI && timeout) err_q <= 1'b1;
        end
    end

    assign tx_err_o = err_q;
`else
    assign timeout  = 1'b0;
    assign tx_err_o = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prefer_b_q <= 1'b0;
            data_q     <= '0;
            hold_q     <= '0;
            byte_idx_q <= '0;
            byte_cnt_q <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            valid_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prefer_b_q <= prefer_b_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            byte_idx_q <= byte_idx_d;
            byte_cnt_q <= byte_cnt_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            valid_q    <= valid_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            busy_q     <= busy_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (grant_a || grant_b) state_d = S_PULSE;
            S_PULSE:   if (!tx_busy_i) state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (tx_busy_i)    state_d = S_WAIT_LO;
                else if (timeout) state_d = S_PULSE;
            end
            S_WAIT_LO: begin
                if (!tx_busy_i)
                    state_d = (byte_idx_q < byte_cnt_q - 2'd1) ? S_PULSE : S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prefer_b_d = prefer_b_q;
        data_d     = data_q;
        hold_d     = hold_q;
        byte_idx_d = byte_idx_q;
        byte_cnt_d = byte_cnt_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        valid_d    = 1'b0;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        busy_d     = (state_d != S_IDLE);
        if (grant_a || grant_b) begin
            a_ack_d    = grant_a;
            b_ack_d    = grant_b;
            data_d     = grant_a ? a_data_i : b_data_i[DATA_WIDTH-1:0];
            hold_d     = b_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
            byte_idx_d = 2'd0;
            byte_cnt_d = grant_a ? 2'd1 : 2'd2;
            par_en_d   = cfg_par_en_i;
            par_type_d = cfg_par_type_i;
            prefer_b_d = grant_a;
        end
        if (state_q == S_PULSE && !tx_busy_i) valid_d = 1'b1;
        // Upper byte moves onto the bus only once the transmitter has finished the lower one.
        if (state_q == S_WAIT_LO && !tx_busy_i && byte_idx_q < byte_cnt_q - 2'd1) begin
            byte_idx_d = byte_idx_q + 2'd1;
            data_d     = hold_q;
        end
    end

    assign a_ack_o         = a_ack_q;
    assign b_ack_o         = b_ack_q;
    assign tx_p_data_o     = data_q;
    assign tx_data_valid_o = valid_q;
    assign tx_par_en_o     = par_en_q;
    assign tx_par_type_o   = par_type_q;
    assign sched_busy_o    = busy_q;

endmodule
